// File: rtl/alu_issue.sv
// -----------------------------------------------------------------------------
// alu_issue
//   Issues one operation at a time to an external combinational ALU.
//   A request is latched in IDLE, driven onto the ALU in EXEC, and the
//   ALU result is held in DONE until the consumer takes it. The block
//   itself performs no arithmetic beyond the completed-operation counter.
//
// Ports
//   clk                 sole clock, all state on the rising edge
//   reset               asynchronous, active-low reset
//   in_valid/in_ready   request handshake (ready only in IDLE)
//   in_op, in_a, in_b   request opcode and operands
//   in_use_acc          take operand A from the accumulator instead of in_a
//   acc_clr             synchronous accumulator clear, honoured in any state
//   alu_a/alu_b/alu_op  operands and opcode presented to the downstream ALU
//   alu_c               combinational result returned by the ALU
//   out_valid/out_ready result handshake (valid only in DONE)
//   out_data            registered ALU result
//   acc                 accumulator (last result unless cleared)
//   op_count            completed operations, wraps silently
// -----------------------------------------------------------------------------
module alu_issue #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_use_acc,
    input  logic             acc_clr,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [WIDTH-1:0] acc,
    output logic [CNTW-1:0]  op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_acc;
    logic [CNTW-1:0]  r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_op        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_out       <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_op       <= in_op;
                        // r_acc here is the value before any same-edge clear.
                        r_a        <= in_use_acc ? r_acc : in_a;
                        r_b        <= in_b;
                        r_in_ready <= 1'b0;
                        r_state    <= EXEC;
                    end
                end
                EXEC: begin
                    r_out       <= alu_c;
                    r_acc       <= alu_c;
                    r_cnt       <= r_cnt + CNTW'(1);
                    r_out_valid <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
            // NOTE: with non-blocking assignments the last one in the block
            // takes effect, so this clear overrides the EXEC capture above.
            if (acc_clr) begin
                r_acc <= '0;
            end
        end
    end

    // Every output comes straight from a register: the ALU inputs never
    // follow the request bus, and out_valid never depends on out_ready.
    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign alu_a     = r_a;
    assign alu_b     = r_b;
    assign alu_op    = r_op;
    assign out_data  = r_out;
    assign acc       = r_acc;
    assign op_count  = r_cnt;

endmodule

// File: tb/tb_alu_issue.sv
// -----------------------------------------------------------------------------
// tb_alu_issue
//   Self-checking bench for alu_issue with a behavioural downstream ALU.
//   A transaction-level model tracks the accumulator, last result and
//   operation count; directed cases are followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_alu_issue;

    localparam int W  = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_op;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          in_use_acc;
    logic          acc_clr;
    logic [W-1:0]  alu_a;
    logic [W-1:0]  alu_b;
    logic [2:0]    alu_op;
    logic [W-1:0]  alu_c;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [W-1:0]  acc;
    logic [CW-1:0] op_count;

    int n_total = 0;
    int n_bad   = 0;

    // transaction-level model state
    logic [W-1:0] m_acc;
    logic [W-1:0] m_out;
    int           m_cnt;

    always #5 clk = ~clk;

    // Downstream ALU: 000 add, 001 sub, then logic/shift ops.
    function automatic logic [W-1:0] alu_f(input logic [2:0] op,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return a << b[4:0];
            3'd6:    return a >> b[4:0];
            default: return a;
        endcase
    endfunction

    assign alu_c = alu_f(alu_op, alu_a, alu_b);

    alu_issue #(.WIDTH(W), .CNTW(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_use_acc (in_use_acc),
        .acc_clr    (acc_clr),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_c      (alu_c),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .acc        (acc),
        .op_count   (op_count)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_acc = '0;
        m_out = '0;
        m_cnt = 0;
    endtask

    // One complete transaction: accept, execute, hold in DONE, hand back.
    task automatic do_op(input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic use_acc,
                         input int hold, input logic clr_accept,
                         input logic clr_exec, input logic clr_done);
        logic [W-1:0] exp_a;
        exp_a = use_acc ? m_acc : a;
        chk("idle_ready", in_ready, 1);
        in_valid   = 1'b1;
        in_op      = op;
        in_a       = a;
        in_b       = b;
        in_use_acc = use_acc;
        acc_clr    = clr_accept;
        tick();
        if (clr_accept) m_acc = '0;
        // scramble the request bus: the latched operation must not follow it
        in_valid   = 1'b0;
        in_op      = 3'($urandom);
        in_a       = $urandom;
        in_b       = $urandom;
        in_use_acc = 1'($urandom);
        acc_clr    = clr_exec;
        chk("exec_ready", in_ready, 0);
        chk("exec_valid", out_valid, 0);
        chk("exec_alu_a", alu_a, exp_a);
        chk("exec_alu_b", alu_b, b);
        chk("exec_alu_op", alu_op, op);
        chk("exec_acc", acc, m_acc);
        tick();
        m_out = alu_f(op, exp_a, b);
        m_acc = clr_exec ? '0 : m_out;
        m_cnt = (m_cnt + 1) % (1 << CW);
        acc_clr = 1'b0;
        chk("done_valid", out_valid, 1);
        chk("done_ready", in_ready, 0);
        chk("done_data", out_data, m_out);
        chk("done_acc", acc, m_acc);
        chk("done_cnt", op_count, 64'(m_cnt));
        for (int i = 0; i < hold; i++) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_a      = $urandom;
            acc_clr   = (i == 0) && clr_done;
            tick();
            if ((i == 0) && clr_done) m_acc = '0;
            acc_clr = 1'b0;
            chk("hold_valid", out_valid, 1);
            chk("hold_ready", in_ready, 0);
            chk("hold_data", out_data, m_out);
            chk("hold_acc", acc, m_acc);
            chk("hold_cnt", op_count, 64'(m_cnt));
            chk("hold_alu_a", alu_a, exp_a);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("ret_valid", out_valid, 0);
        chk("ret_ready", in_ready, 1);
        chk("ret_data", out_data, m_out);
        chk("ret_alu_a", alu_a, exp_a);
        chk("ret_alu_b", alu_b, b);
        chk("ret_alu_op", alu_op, op);
    endtask

    initial begin
        reset      = 1'b0;
        in_valid   = 1'b0;
        in_op      = '0;
        in_a       = '0;
        in_b       = '0;
        in_use_acc = 1'b0;
        acc_clr    = 1'b0;
        out_ready  = 1'b0;
        model_reset();
        repeat (2) tick();
        chk("rst_ready", in_ready, 1);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_acc", acc, 0);
        chk("rst_cnt", op_count, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_op", alu_op, 0);
        reset = 1'b1;

        // 5 + 3, then acc - 2 with in_a ignored
        do_op(3'd0, 32'd5, 32'd3, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        chk("add_data", out_data, 8);
        chk("add_acc", acc, 8);
        chk("add_cnt", op_count, 1);
        do_op(3'd1, 32'hDEADBEEF, 32'd2, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        chk("accsub_data", out_data, 6);
        chk("accsub_acc", acc, 6);

        // consumer stalls five cycles with a second request pending
        do_op(3'd4, 32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 5, 1'b0, 1'b0, 1'b0);

        // clear coincident with capture, then clear while in DONE
        do_op(3'd0, 32'hFFFF_FFFF, 32'd1, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        chk("clrexec_data", out_data, 0);
        chk("clrexec_acc", acc, 0);
        do_op(3'd0, 32'd9, 32'd4, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        chk("clrexec2_data", out_data, 13);
        chk("clrexec2_acc", acc, 0);
        do_op(3'd0, 32'd3, 32'd4, 1'b0, 2, 1'b0, 1'b0, 1'b1);
        chk("clrdone_data", out_data, 7);
        chk("clrdone_acc", acc, 0);

        // accumulator operand sampled on the same edge as a clear
        do_op(3'd0, 32'd20, 32'd1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        do_op(3'd0, 32'd0, 32'd100, 1'b1, 0, 1'b1, 1'b0, 1'b0);
        chk("preclr_data", out_data, 121);

        // asynchronous reset in the middle of EXEC
        in_valid = 1'b1;
        in_op    = 3'd0;
        in_a     = 32'd77;
        in_b     = 32'd1;
        in_use_acc = 1'b0;
        tick();
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("arst_ready", in_ready, 1);
        chk("arst_valid", out_valid, 0);
        chk("arst_data", out_data, 0);
        chk("arst_acc", acc, 0);
        chk("arst_cnt", op_count, 0);
        chk("arst_alu_a", alu_a, 0);
        chk("arst_alu_b", alu_b, 0);
        chk("arst_alu_op", alu_op, 0);
        tick();
        chk("arst_hold_cnt", op_count, 0);
        reset = 1'b1;
        model_reset();

        // counter wrap: 15 ops reach the top, the 16th returns to zero
        for (int i = 0; i < 15; i++) begin
            do_op(3'($urandom), $urandom, $urandom, 1'($urandom), 0, 1'b0, 1'b0, 1'b0);
        end
        chk("wrap_top", op_count, 15);
        do_op(3'd0, 32'd1, 32'd1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        chk("wrap_zero", op_count, 0);

        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            logic c_acc;
            logic c_exe;
            logic c_done;
            c_acc  = ($urandom_range(0, 7) == 0);
            c_exe  = ($urandom_range(0, 7) == 0);
            c_done = ($urandom_range(0, 7) == 0);
            do_op(3'($urandom), $urandom, $urandom, 1'($urandom),
                  $urandom_range(1, 3), c_acc, c_exe, c_done);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
